ram_burst_reader: RTL and testbench
===================================

Name: ram_burst_reader

Overview:
- Read-side initiator for a synchronous RAM port with a registered read output (one-cycle read latency, no write from this block).
- On `start`, issues `len` sequential reads beginning at `base_addr`, then emits the words as a valid/ready stream with full backpressure support.
- Sits between a dual-port buffer and a downstream consumer such as a UART TX or video path, while another agent writes the opposite port.

Parameters:
- DATA_WIDTH, 8, RAM word width in bits.
- ADDR_WIDTH, 10, RAM address width; address space is 2**ADDR_WIDTH words.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  burst request; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first word address; captured on accepted start.
- len  input  ADDR_WIDTH+1  number of words, 0 to 2**ADDR_WIDTH; captured on accepted start.
- busy  output  1  high from the cycle after an accepted start until the burst completes.
- done  output  1  single-cycle pulse when the burst completes.
- ram_addr  output  ADDR_WIDTH  address driven to the RAM port; the RAM samples it every edge.
- ram_dout  input  DATA_WIDTH  RAM read data; valid one cycle after the address was sampled.
- m_data  output  DATA_WIDTH  stream data.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready from the consumer.

Behaviour:
- Reset: busy=0, done=0, m_valid=0, m_data=0, ram_addr=0; FSM in IDLE; FIFO empty; in-flight flag cleared.
- Reset asserted mid-burst aborts the burst immediately; no done pulse is generated.
- FSM states: IDLE, READ, DRAIN.
  - IDLE -> READ when start=1 and len!=0.
  - IDLE with start=1 and len=0: done pulses the next cycle and the FSM stays in IDLE; busy never asserts.
  - READ -> DRAIN when the final read is issued.
  - DRAIN -> IDLE when the final word is handshaken.
  - start is ignored while busy.
- Issue:
  - Read issue is internal signal `rd_issue`, asserted in READ when (fifo_count + inflight - pop) < 2, where pop = m_valid & m_ready.
  - ram_addr is combinational from the address counter register; the counter increments on each issue.
  - The address wraps modulo 2**ADDR_WIDTH, so 0x3FF is followed by 0x000.
  - A remaining-word counter of ADDR_WIDTH+1 bits decrements on each issue.
- Capture:
  - `inflight` is a registered copy of rd_issue.
  - When inflight=1, ram_dout is pushed into a 2-entry FIFO at that cycle's edge.
  - The FIFO head drives m_data and m_valid directly from registers; there is no combinational path from ram_dout to m_data.
- Latency:
  - start sampled at edge E0 -> first issue in cycle 1 -> m_valid=1 in cycle 3.
  - With m_ready held high, one word per cycle is sustained.
- Stream handshake: m_data and m_valid hold stable while m_valid=1 and m_ready=0. The FIFO can never overflow; the credit rule guarantees this.
- Completion: the cycle after the last handshake, busy=0 and done=1 for exactly one cycle.
- A new start is accepted in the done cycle.
- len=2**ADDR_WIDTH reads the whole RAM exactly once, ending at base_addr-1 modulo the address space.

Optional Feature:
- Macro RB_LAST_EN.
- Defined: adds output port m_last (1 bit), high together with m_valid on the final word of a burst. It is tracked as a per-entry tag in the FIFO.
- Undefined: the port is absent and no tag storage is built.

Decomposition:
- Package ram_burst_pkg: FSM state enum (IDLE, READ, DRAIN) and the FIFO depth constant RB_FIFO_DEPTH=2.
- Sub-module rb_skid_fifo: the 2-entry register FIFO with push, pop, count, head data, and the optional last tag.

Test Plan:
- Wrap-around: RAM preloaded with data=addr[7:0]; base=0x3FE, len=4, m_ready=1 -> m_data 0xFE, 0xFF, 0x00, 0x01 on consecutive cycles starting cycle 3; done pulses once.
- Backpressure: base=0x010, len=6, m_ready pattern 1,0,0,1,0,1,1,1,1 -> all 6 words in order, none lost or duplicated; m_data stable while stalled; ram_addr never issued more than 2 ahead of consumption.
- Zero length: len=0 start -> busy stays 0, done=1 in the next cycle, m_valid never asserts.
- Start while busy: second start during a len=8 burst is ignored -> exactly 8 beats, single done pulse.
- Reset mid-burst: reset_n low during beat 3 of len=10 -> outputs go to 0 at once with no done pulse; a new burst after release runs correctly from its base.
- Optional feature: with RB_LAST_EN and len=1 and len=5 -> m_last high only on the single beat and on the 5th beat respectively.

Source files
------------

// File: rtl/ram_burst_pkg.sv
// ram_burst_pkg
//   Shared types and constants for the RAM burst reader.
//   - rb_state_t    : burst FSM state (IDLE, READ, DRAIN)
//   - RB_FIFO_DEPTH : depth of the output skid FIFO
//   - RB_CNT_W      : width of a FIFO occupancy count (0..RB_FIFO_DEPTH)
package ram_burst_pkg;

    localparam int RB_FIFO_DEPTH = 2;
    localparam int RB_CNT_W      = $clog2(RB_FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } rb_state_t;

endpackage

// File: rtl/rb_skid_fifo.sv
// rb_skid_fifo
//   Two-entry register FIFO that sits between the RAM read data and the
//   output stream. Entry 0 is always the head, so the stream outputs come
//   straight from flops with no path back to the push data.
//   Optional macro RB_LAST_EN adds a one-bit "last" tag per entry.
// Ports:
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_push            write i_push_data (and i_push_last) this edge
//   i_push_data       word to store
//   i_push_last       end-of-burst tag (RB_LAST_EN only)
//   i_pop             head consumed this edge
//   o_count           current occupancy, 0..2
//   o_head_data       head word
//   o_head_valid      FIFO not empty
//   o_head_last       head tag (RB_LAST_EN only)
module rb_skid_fifo
    import ram_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [RB_CNT_W-1:0]   o_count,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic                  o_head_valid
`ifdef RB_LAST_EN
    ,
    input  logic                  i_push_last,
    output logic                  o_head_last
`endif
);

`ifdef RB_LAST_EN
    localparam int ENTRY_W = DATA_WIDTH + 1;
`else
    localparam int ENTRY_W = DATA_WIDTH;
`endif

    logic [ENTRY_W-1:0]  r_entry0;
    logic [ENTRY_W-1:0]  r_entry1;
    logic [RB_CNT_W-1:0] r_count;
    logic [ENTRY_W-1:0]  w_push_entry;

`ifdef RB_LAST_EN
    assign w_push_entry = {i_push_last, i_push_data};
    assign o_head_last  = r_entry0[DATA_WIDTH];
`else
    assign w_push_entry = i_push_data;
`endif

    // Shift structure: a pop moves entry 1 into the head slot, a push fills
    // the first free slot. The credit rule upstream never pushes when full
    // and never pops when empty, so those cases need no guarding here.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            // NOTE: the storage is reset because the head word is a visible
            // output that must read as zero out of reset.
            r_entry0 <= '0;
            r_entry1 <= '0;
            r_count  <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == RB_CNT_W'(0)) r_entry0 <= w_push_entry;
                    else                         r_entry1 <= w_push_entry;
                    r_count <= r_count + RB_CNT_W'(1);
                end
                2'b01: begin
                    r_entry0 <= r_entry1;
                    r_count  <= r_count - RB_CNT_W'(1);
                end
                2'b11: begin
                    if (r_count == RB_CNT_W'(1)) begin
                        r_entry0 <= w_push_entry;
                    end else begin
                        r_entry0 <= r_entry1;
                        r_entry1 <= w_push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_count      = r_count;
    assign o_head_data  = r_entry0[DATA_WIDTH-1:0];
    assign o_head_valid = (r_count != RB_CNT_W'(0));

endmodule

// File: rtl/ram_burst_reader.sv
// ram_burst_reader
//   Reads `len` consecutive words from a synchronous RAM (one-cycle read
//   latency) starting at `base_addr` and streams them out on a valid/ready
//   interface with full backpressure. Addresses wrap modulo 2**ADDR_WIDTH.
//   Optional macro RB_LAST_EN adds the m_last output, high on the final beat.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   start         burst request (sampled in IDLE only)
//   base_addr     first address, captured on an accepted start
//   len           word count 0..2**ADDR_WIDTH, captured on an accepted start
//   busy          burst in progress
//   done          one-cycle completion pulse
//   ram_addr      RAM read address
//   ram_dout      RAM read data (one cycle after the address)
//   m_data, m_valid, m_ready   output stream
//   m_last        final-beat marker (RB_LAST_EN only)
module ram_burst_reader
    import ram_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
`ifdef RB_LAST_EN
    ,
    output logic                  m_last
`endif
);

    rb_state_t             r_state;
    rb_state_t             w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic                  r_inflight;
    logic                  r_done;

    logic                  w_pop;
    logic                  w_rd_issue;
    logic                  w_final_issue;
    logic                  w_final_pop;
    logic                  w_start_burst;
    logic                  w_start_empty;
    logic                  w_busy;
    logic [RB_CNT_W-1:0]   w_fifo_count;
    logic [RB_CNT_W:0]     w_credit;

    assign w_pop = m_valid & m_ready;

    // Words already owed to the FIFO (stored plus one in the RAM pipeline),
    // net of the word leaving this cycle. Issuing only below the FIFO depth
    // means a push can never find the FIFO full.
    assign w_credit = {1'b0, w_fifo_count}
                    + (RB_CNT_W + 1)'(r_inflight)
                    - (RB_CNT_W + 1)'(w_pop);

    assign w_final_issue = w_rd_issue && (r_remaining == (ADDR_WIDTH + 1)'(1));
    // In DRAIN every read is issued, so the last word leaves when the FIFO
    // holds one word and nothing is still coming back from the RAM.
    assign w_final_pop   = w_pop && (w_fifo_count == RB_CNT_W'(1)) && !r_inflight;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state logic
    // NOTE: a default assignment at the top of every combinational block
    // keeps all paths assigned, so no latch can be inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start && (len != '0)) w_state_next = READ;
            READ:    if (w_final_issue)        w_state_next = DRAIN;
            DRAIN:   if (w_final_pop)          w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_busy        = 1'b0;
        w_rd_issue    = 1'b0;
        w_start_burst = 1'b0;
        w_start_empty = 1'b0;
        case (r_state)
            IDLE: begin
                w_start_burst = start && (len != '0);
                w_start_empty = start && (len == '0);
            end
            READ: begin
                w_busy     = 1'b1;
                w_rd_issue = (w_credit < (RB_CNT_W + 1)'(RB_FIFO_DEPTH));
            end
            DRAIN:   w_busy = 1'b1;
            default: ;
        endcase
    end

    // Address / remaining counters, read pipeline flag, completion pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_start_burst) begin
                r_addr      <= base_addr;
                r_remaining <= len;
            end else if (w_rd_issue) begin
                r_addr      <= r_addr + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - (ADDR_WIDTH + 1)'(1);
            end
            r_inflight <= w_rd_issue;
            r_done     <= w_start_empty || ((r_state == DRAIN) && w_final_pop);
        end
    end

`ifdef RB_LAST_EN
    // Tag travels alongside the in-flight read so it lands with its word.
    logic r_inflight_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_inflight_last <= 1'b0;
        else          r_inflight_last <= w_final_issue;
    end
`endif

    rb_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_push       (r_inflight),
        .i_push_data  (ram_dout),
        .i_pop        (w_pop),
        .o_count      (w_fifo_count),
        .o_head_data  (m_data),
        .o_head_valid (m_valid)
`ifdef RB_LAST_EN
        ,
        .i_push_last  (r_inflight_last),
        .o_head_last  (m_last)
`endif
    );

    assign busy     = w_busy;
    assign done     = r_done;
    assign ram_addr = r_addr;

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader
//   Self-checking bench for ram_burst_reader. A behavioural RAM answers
//   reads one cycle late; each burst's expected beats are computed as
//   mem[(base + i) mod 2**AW] and consumed by a scoreboard as handshakes
//   occur, alongside cycle-level checks of busy, done, latency and stalls.
module tb_ram_burst_reader;

    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          start     = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len       = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout  = '0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready   = 1'b0;
`ifdef RB_LAST_EN
    logic          m_last;
`endif

    ram_burst_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
`ifdef RB_LAST_EN
        ,
        .m_last    (m_last)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural RAM: registered read output.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) ram_dout <= mem[ram_addr];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];

    int bp_pat[9] = '{1, 0, 0, 1, 0, 1, 1, 1, 1};

    // mode 0: always ready; 1: random; 2: fixed pattern from cycle 3 onward
    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            1:       return ($urandom_range(0, 1) == 1);
            2:       return (c >= 3 && c < 12) ? (bp_pat[c-3] == 1) : 1'b1;
            default: return 1'b1;
        endcase
    endfunction

    // Run one burst from start to a couple of cycles past done.
    // start2_c > 0 : raise a second (ignored) start in that cycle.
    // abort_hs > 0 : assert reset right after that many handshakes and return.
    task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] n,
                             input int rmode, input int start2_c, input int abort_hs);
        int            hs;
        int            last_hs_c;
        int            done_c;
        int            first_v_c;
        int            budget;
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          exp_busy;
        logic [AW-1:0] issued;

        exp_q.delete();
        for (int i = 0; i < int'(n); i++) begin
            beat_t e;
            e.data = mem[(int'(b) + i) % DEPTH];
            e.last = (i == int'(n) - 1);
            exp_q.push_back(e);
        end

        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = b;
        len       = n;
        m_ready   = ready_for(rmode, 0);

        hs         = 0;
        last_hs_c  = (n == '0) ? 0 : -100;
        done_c     = -1;
        first_v_c  = -1;
        prev_stall = 1'b0;
        prev_data  = '0;
        budget     = 4 * int'(n) + 20;

        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            start = (c == start2_c);
            if (c == start2_c) begin
                base_addr = AW'($urandom);
                len       = (AW + 1)'(3);
            end
            m_ready = ready_for(rmode, c);

            @(negedge clk);
            if (prev_stall)
                check("stall_hold", 32'({m_valid, m_data}), 32'({1'b1, prev_data}));
            if (m_valid && first_v_c < 0) begin
                first_v_c = c;
                check("first_valid_cycle", c, 3);
            end
            if (c == 1 && n != '0) check("first_addr", 32'(ram_addr), 32'(b));

            exp_busy = (n != '0) && (last_hs_c < 0 || c <= last_hs_c);
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(c == last_hs_c + 1));
            if (done && done_c < 0) done_c = c;
            if (n == '0) check("zlen_valid", 32'(m_valid), 0);
            if (rmode == 0 && n != '0 && c >= 3 && hs < int'(n))
                check("sustain_valid", 32'(m_valid), 1);

            if (busy) begin
                issued = ram_addr - b;
                check("credit", 32'((int'(issued) - hs) <= 2), 1);
            end

            if (m_valid && m_ready) begin
                hs++;
                if (exp_q.size() == 0) begin
                    check("beat_count", hs, int'(n));
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("data", 32'(m_data), 32'(e.data));
`ifdef RB_LAST_EN
                    check("last", 32'(m_last), 32'(e.last));
`endif
                    if (exp_q.size() == 0) last_hs_c = c;
                end
                if (abort_hs > 0 && hs == abort_hs) begin
                    reset_n = 1'b0;
                    #1;
                    check("abort_busy",     32'(busy),     0);
                    check("abort_done",     32'(done),     0);
                    check("abort_valid",    32'(m_valid),  0);
                    check("abort_data",     32'(m_data),   0);
                    check("abort_ram_addr", 32'(ram_addr), 0);
                    exp_q.delete();
                    return;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;

            if (done_c > 0 && c >= done_c + 2) break;
        end

        check("done_seen", 32'(done_c > 0), 1);
        check("leftover", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",     32'(busy),     0);
        check("rst_done",     32'(done),     0);
        check("rst_valid",    32'(m_valid),  0);
        check("rst_data",     32'(m_data),   0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        reset_n = 1'b1;

        // Address wrap, full throughput
        run_burst(10'h3FE, 11'd4, 0, 0, 0);
        // Fixed backpressure pattern
        run_burst(10'h010, 11'd6, 2, 0, 0);
        // Zero length
        run_burst(10'h123, 11'd0, 0, 0, 0);
        // Start while busy is ignored
        run_burst(10'h200, 11'd8, 1, 4, 0);

        // Reset mid-burst, then a clean burst from a new base
        run_burst(10'h050, 11'd10, 0, 0, 3);
        repeat (3) begin
            @(negedge clk);
            check("reset_hold_done", 32'(done), 0);
        end
        reset_n = 1'b1;
        run_burst(10'h3F0, 11'd10, 1, 0, 0);

        // Single-beat and five-beat bursts (final-beat marker when enabled)
        run_burst(10'h001, 11'd1, 0, 0, 0);
        run_burst(10'h100, 11'd5, 1, 0, 0);

        // Randomised bursts over random RAM contents
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        for (int k = 0; k < 8; k++)
            run_burst(AW'($urandom), (AW + 1)'($urandom_range(1, 40)),
                      int'($urandom_range(0, 1)), 0, 0);

        // Whole address space from a random base
        run_burst(AW'($urandom), (AW + 1)'(DEPTH), 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
